// File: rtl/xbus_arbiter_pkg.sv
// Shared widths, state encoding and request payload for the picoversat bus arbiter.
package xbus_arbiter_pkg;

  localparam int unsigned XB_ADDR_W = 12;
  localparam int unsigned XB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } xbus_state_e;

  // One master's request payload as seen by the arbiter.
  typedef struct packed {
    logic [XB_ADDR_W-1:0] addr;
    logic                 we;
    logic [XB_DATA_W-1:0] wdata;
    logic                 lock;
  } xbus_req_t;

endpackage

// File: rtl/xbus_rr_pick.sv
// Combinational 2-way round-robin picker with lock-reservation override.
module xbus_rr_pick (
  input  logic [1:0] elig_i,
  input  logic       rr_last_i,
  input  logic       resv_vld_i,
  input  logic       resv_own_i,
  output logic       win_c,
  output logic       vld_c
);

  // Reserved owner wins if it asks; otherwise the master that did not win last breaks ties.
  always_comb begin
    win_c = 1'b0;
    vld_c = |elig_i;
    if (resv_vld_i && elig_i[resv_own_i]) begin
      win_c = resv_own_i;
    end else if (&elig_i) begin
      win_c = ~rr_last_i;
    end else begin
      win_c = elig_i[1];
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// Two-master arbiter serializing controller and DMA requests onto the internal bus.
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req,
  input  logic [XB_ADDR_W-1:0] m0_addr,
  input  logic                 m0_we,
  input  logic [XB_DATA_W-1:0] m0_wdata,
  input  logic                 m0_lock,
  output logic                 m0_ack,
  output logic                 m0_err,
  output logic [XB_DATA_W-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic [XB_ADDR_W-1:0] m1_addr,
  input  logic                 m1_we,
  input  logic [XB_DATA_W-1:0] m1_wdata,
  input  logic                 m1_lock,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic [XB_DATA_W-1:0] m1_rdata,
  output logic                 bus_sel,
  output logic [XB_ADDR_W-1:0] bus_addr,
  output logic                 bus_we,
  output logic [XB_DATA_W-1:0] bus_wdata,
  input  logic [XB_DATA_W-1:0] bus_rdata,
  input  logic                 bus_trap
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  xbus_state_e                     state_q;
  logic                            sel_q;
  logic                            we_q;
  logic [XB_ADDR_W-1:0]            addr_q;
  logic [XB_DATA_W-1:0]            wdata_q;
  logic                            gnt_q;
  logic                            gnt_we_q;
  logic                            gnt_lock_q;
  logic                            trap_q;
  logic [1:0]                      ack_q;
  logic [1:0]                      err_q;
  logic [1:0][XB_DATA_W-1:0]       rdata_q;
  logic                            rr_last_q;
  logic                            resv_q;
  logic [CNT_W-1:0]                lock_cnt_q;

  xbus_req_t  m0_pl_c;
  xbus_req_t  m1_pl_c;
  xbus_req_t  win_pl_c;
  logic [1:0] elig_c;
  logic [1:0] pick_elig_c;
  logic       resv_take_c;
  logic       win_c;
  logic       vld_c;

  assign m0_pl_c = '{addr: m0_addr, we: m0_we, wdata: m0_wdata, lock: m0_lock};
  assign m1_pl_c = '{addr: m1_addr, we: m1_we, wdata: m1_wdata, lock: m1_lock};

  // The master acked this cycle may not win again until the next cycle.
  assign elig_c = {m1_req & ~ack_q[1], m0_req & ~ack_q[0]};

  // In the ack cycle a locking master keeps the bus idle for itself, up to the fairness bound.
  assign resv_take_c = (state_q == ST_IDLE) && (|ack_q) && gnt_lock_q &&
                       ((32'(lock_cnt_q) + 32'd1) < LOCK_MAX);

  assign pick_elig_c = resv_take_c ? 2'b00 : elig_c;
  assign win_pl_c    = win_c ? m1_pl_c : m0_pl_c;

  xbus_rr_pick u_pick (
    .elig_i     (pick_elig_c),
    .rr_last_i  (rr_last_q),
    .resv_vld_i (resv_q),
    .resv_own_i (gnt_q),
    .win_c      (win_c),
    .vld_c      (vld_c)
  );

  // Transaction FSM, bus drive registers, response registers and lock bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_q      <= 1'b0;
      gnt_we_q   <= 1'b0;
      gnt_lock_q <= 1'b0;
      trap_q     <= 1'b0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      rr_last_q  <= 1'b1;
      resv_q     <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (resv_take_c) begin
            resv_q     <= 1'b1;
            lock_cnt_q <= lock_cnt_q + CNT_W'(1);
          end else begin
            resv_q <= 1'b0;
            if (vld_c) begin
              state_q    <= ST_ADDR;
              sel_q      <= 1'b1;
              we_q       <= win_pl_c.we;
              addr_q     <= win_pl_c.addr;
              wdata_q    <= win_pl_c.wdata;
              gnt_q      <= win_c;
              gnt_we_q   <= win_pl_c.we;
              gnt_lock_q <= win_pl_c.lock;
              rr_last_q  <= win_c;
              if (!(resv_q && (win_c == gnt_q))) begin
                lock_cnt_q <= '0;
              end
            end else if (resv_q || (|ack_q)) begin
              lock_cnt_q <= '0;
            end
          end
        end
        ST_ADDR: begin
          sel_q   <= 1'b0;
          we_q    <= 1'b0;
          trap_q  <= bus_trap;
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          ack_q[gnt_q]   <= 1'b1;
          err_q[gnt_q]   <= trap_q;
          rdata_q[gnt_q] <= (gnt_we_q || trap_q) ? '0 : bus_rdata;
          state_q        <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_sel   = sel_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];

endmodule
